// File: rtl/branch_predictor.sv
// Fetch-side BTB + 2-bit BHT predictor, registered one cycle after request.
// Ports: req_*/f_stall lookup in, pred_* out, upd_* training in; BP_RAS_EN adds a return stack.
module branch_predictor #(
  parameter int ENTRIES   = 64,
  parameter int RAS_DEPTH = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  input  logic [31:0] req_pc,
  input  logic        f_stall,
  output logic        pred_valid,
  output logic        pred_pre_b,
  output logic [31:0] pred_pre_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic [1:0]  upd_type,
  input  logic        upd_call
);
  localparam int IDX = $clog2(ENTRIES);
  localparam int TAG = 30 - IDX;

  typedef struct packed {
    logic           valid;
    logic [TAG-1:0] tag;
    logic [31:0]    target;
    logic [1:0]     typ;
    logic [1:0]     ctr;
  } entry_t;

  entry_t tbl_q [ENTRIES];
  entry_t tbl_d [ENTRIES];

  logic        pred_valid_q, pred_valid_d;
  logic        pred_pre_b_q, pred_pre_b_d;
  logic [31:0] pred_pre_pc_q, pred_pre_pc_d;

  logic [IDX-1:0] r_idx, u_idx;
  entry_t         r_e, u_e;
  logic           r_hit, u_hit, r_taken;
  logic [31:0]    r_tgt;

  assign r_idx = req_pc[IDX+1:2];
  assign u_idx = upd_pc[IDX+1:2];
  assign r_e   = tbl_q[r_idx];
  assign u_e   = tbl_q[u_idx];
  assign r_hit = r_e.valid && (r_e.tag == req_pc[31:IDX+2]);
  assign u_hit = u_e.valid && (u_e.tag == upd_pc[31:IDX+2]);
  assign r_taken = r_hit && ((r_e.typ != 2'b00) || r_e.ctr[1]);

`ifdef BP_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [31:0]   ras_q [RAS_DEPTH];
  logic [31:0]   ras_d [RAS_DEPTH];
  logic [PW-1:0] ras_ptr_q, ras_ptr_d, ras_top;
  logic [CW-1:0] ras_cnt_q, ras_cnt_d;
  logic          push, pop;
  logic [31:0]   ret_addr;
  logic [1:0]    unused_lsb;

  assign unused_lsb = req_pc[1:0] ^ upd_pc[1:0];
  assign ras_top  = ras_ptr_q - PW'(1);
  assign push     = upd_valid && upd_call;
  assign pop      = upd_valid && (upd_type == 2'b11);
  assign ret_addr = upd_pc + 32'd8;

  always_comb begin
    r_tgt = r_e.target;
    if (r_e.typ == 2'b11 && ras_cnt_q != '0)
      r_tgt = ras_q[ras_top];
  end

  // Ptr points at the next free slot; when full that slot is the oldest.
  always_comb begin
    ras_d     = ras_q;
    ras_ptr_d = ras_ptr_q;
    ras_cnt_d = ras_cnt_q;
    if (push && pop) begin
      ras_d[ras_top] = ret_addr;
    end else if (push) begin
      ras_d[ras_ptr_q] = ret_addr;
      ras_ptr_d = ras_ptr_q + PW'(1);
      if (ras_cnt_q != CW'(RAS_DEPTH))
        ras_cnt_d = ras_cnt_q + CW'(1);
    end else if (pop && ras_cnt_q != '0) begin
      ras_ptr_d = ras_top;
      ras_cnt_d = ras_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
      ras_ptr_q <= '0;
      ras_cnt_q <= '0;
    end else begin
      ras_q     <= ras_d;
      ras_ptr_q <= ras_ptr_d;
      ras_cnt_q <= ras_cnt_d;
    end
  end
`else
  logic [2:0] unused_in;
  assign unused_in = {req_pc[1:0] ^ upd_pc[1:0], upd_call};
  assign r_tgt = r_e.target;
`endif

  always_comb begin
    tbl_d = tbl_q;
    if (upd_valid) begin
      if (u_hit) begin
        tbl_d[u_idx].target = upd_target;
        tbl_d[u_idx].typ    = upd_type;
        if (upd_taken)
          tbl_d[u_idx].ctr = (u_e.ctr == 2'b11) ? 2'b11 : u_e.ctr + 2'd1;
        else
          tbl_d[u_idx].ctr = (u_e.ctr == 2'b00) ? 2'b00 : u_e.ctr - 2'd1;
      end else if (upd_taken) begin
        tbl_d[u_idx] = '{valid:  1'b1,
                         tag:    upd_pc[31:IDX+2],
                         target: upd_target,
                         typ:    upd_type,
                         ctr:    (upd_type == 2'b00) ? 2'b10 : 2'b11};
      end
    end
  end

  always_comb begin
    pred_valid_d  = pred_valid_q;
    pred_pre_b_d  = pred_pre_b_q;
    pred_pre_pc_d = pred_pre_pc_q;
    if (!f_stall) begin
      pred_valid_d  = req_valid;
      pred_pre_b_d  = req_valid && r_taken;
      pred_pre_pc_d = (req_valid && r_taken) ? r_tgt : 32'h0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < ENTRIES; i++)
        tbl_q[i] <= '{valid: 1'b0, tag: '0, target: '0,
                      typ: 2'b00, ctr: 2'b01};
      pred_valid_q  <= 1'b0;
      pred_pre_b_q  <= 1'b0;
      pred_pre_pc_q <= 32'h0;
    end else begin
      tbl_q         <= tbl_d;
      pred_valid_q  <= pred_valid_d;
      pred_pre_b_q  <= pred_pre_b_d;
      pred_pre_pc_q <= pred_pre_pc_d;
    end
  end

  assign pred_valid  = pred_valid_q;
  assign pred_pre_b  = pred_pre_b_q;
  assign pred_pre_pc = pred_pre_pc_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: BHT, BTB aliasing, stall, reset, RAS.
// Checks {pred_valid, pred_pre_b, pred_pre_pc} against hand-computed values.
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_pc = '0;
  logic        f_stall = 1'b0;
  logic        pred_valid, pred_pre_b;
  logic [31:0] pred_pre_pc;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic [1:0]  upd_type = '0;
  logic        upd_call = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_pc(req_pc), .f_stall(f_stall),
    .pred_valid(pred_valid), .pred_pre_b(pred_pre_b),
    .pred_pre_pc(pred_pre_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_type(upd_type), .upd_call(upd_call)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [33:0] exp);
    logic [33:0] obs;
    obs = {pred_valid, pred_pre_b, pred_pre_pc};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_upd(input logic [31:0] pc, input logic tk,
                         input logic [31:0] tgt, input logic [1:0] ty,
                         input logic call);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = tk;
    upd_target = tgt; upd_type = ty; upd_call = call;
  endtask

  task automatic clr();
    upd_valid = 1'b0; upd_call = 1'b0; req_valid = 1'b0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk,
                     input logic [31:0] tgt, input logic [1:0] ty,
                     input logic call);
    set_upd(pc, tk, tgt, ty, call);
    tick();
    clr();
  endtask

  task automatic req(input logic [31:0] pc);
    req_valid = 1'b1; req_pc = pc;
    tick();
    clr();
  endtask

  initial begin
    logic [31:0] e;
    #12;
    chk("reset", {2'b00, 32'h0});
    @(negedge clk);
    resetn = 1'b1;
    tick();

    req(32'hBFC0_0000);
    chk("cold_miss", {2'b10, 32'h0});
    tick();
    chk("idle_clear", {2'b00, 32'h0});

    upd(32'h100, 1'b1, 32'h200, 2'b00, 1'b0);
    req(32'h100);
    chk("br_alloc_taken", {2'b11, 32'h200});
    upd(32'h100, 1'b0, 32'h200, 2'b00, 1'b0);
    req(32'h100);
    chk("br_ctr01", {2'b10, 32'h0});
    upd(32'h100, 1'b0, 32'h200, 2'b00, 1'b0);
    upd(32'h100, 1'b0, 32'h200, 2'b00, 1'b0);
    upd(32'h100, 1'b1, 32'h200, 2'b00, 1'b0);
    req(32'h100);
    chk("br_sat_low", {2'b10, 32'h0});
    upd(32'h100, 1'b1, 32'h200, 2'b00, 1'b0);
    req(32'h100);
    chk("br_ctr10", {2'b11, 32'h200});
    upd(32'h100, 1'b1, 32'h200, 2'b00, 1'b0);
    upd(32'h100, 1'b1, 32'h200, 2'b00, 1'b0);
    upd(32'h100, 1'b0, 32'h200, 2'b00, 1'b0);
    req(32'h100);
    chk("br_sat_high", {2'b11, 32'h200});

    set_upd(32'h108, 1'b1, 32'h300, 2'b00, 1'b0);
    req_valid = 1'b1; req_pc = 32'h108;
    tick();
    clr();
    chk("no_bypass", {2'b10, 32'h0});
    req(32'h108);
    chk("after_update", {2'b11, 32'h300});

    upd(32'h104, 1'b1, 32'h400, 2'b01, 1'b0);
    upd(32'h204, 1'b1, 32'h800, 2'b01, 1'b0);
    req(32'h104);
    chk("alias_evicted", {2'b10, 32'h0});
    req(32'h204);
    chk("alias_new", {2'b11, 32'h800});

    upd(32'h10F, 1'b1, 32'h500, 2'b01, 1'b0);
    req(32'h10C);
    chk("unaligned_upd", {2'b11, 32'h500});
    upd(32'h10C, 1'b1, 32'h600, 2'b10, 1'b0);
    req(32'h10C);
    chk("hit_retarget", {2'b11, 32'h600});
    upd(32'h110, 1'b0, 32'h700, 2'b00, 1'b0);
    req(32'h110);
    chk("nt_no_alloc", {2'b10, 32'h0});

    req(32'h204);
    chk("pre_stall", {2'b11, 32'h800});
    f_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1;
      req_pc = 32'h100 + 32'(i * 4);
      tick();
      chk("stall_hold", {2'b11, 32'h800});
    end
    f_stall = 1'b0;
    req(32'h100);
    chk("unstall", {2'b11, 32'h200});

    resetn = 1'b0;
    #1;
    chk("async_reset", {2'b00, 32'h0});
    @(negedge clk);
    resetn = 1'b1;
    req(32'h100);
    chk("table_cleared", {2'b10, 32'h0});

    upd(32'h2000, 1'b1, 32'h9999, 2'b11, 1'b0);
    upd(32'h1004, 1'b1, 32'h3000, 2'b01, 1'b1);
    req(32'h2000);
`ifdef BP_RAS_EN
    chk("ret_ras", {2'b11, 32'h100C});
`else
    chk("ret_btb", {2'b11, 32'h9999});
`endif
    for (int k = 0; k < 9; k++)
      upd(32'h1104 + 32'(4 * k), 1'b1, 32'h3000, 2'b01, 1'b1);
    for (int k = 8; k >= 1; k--) begin
      set_upd(32'h2000, 1'b1, 32'h9999, 2'b11, 1'b0);
      req_valid = 1'b1; req_pc = 32'h2000;
      tick();
      clr();
`ifdef BP_RAS_EN
      e = 32'h110C + 32'(4 * k);
`else
      e = 32'h9999;
`endif
      chk("ret_pop", {2'b11, e});
    end
    req(32'h2000);
    chk("ret_empty", {2'b11, 32'h9999});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
